// File: rtl/sd_defs_pkg.sv
// Shared definitions for the serial word assembler: FSM encodings, default frame
// width and the odd-parity convention used when judging a received frame.
package sd_defs;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } sd_state_t;

  localparam int SD_WORD_BITS_DEFAULT = 26;

  // A good frame has an odd number of ones across data bits plus parity bit.
  localparam logic SD_ODD_PARITY = 1'b1;

  function automatic logic sd_parity_ok(input logic data_xor, input logic parity_bit);
    return (data_xor ^ parity_bit) == SD_ODD_PARITY;
  endfunction

endpackage

// File: rtl/sd_word_hold.sv
// Holding register for completed words: valid/read handshake and sticky overrun.
// A completion that finds an unread word (and no read this cycle) is dropped.
module sd_word_hold
  import sd_defs::*;
#(
  parameter int WORD_BITS = SD_WORD_BITS_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [WORD_BITS-1:0] word_in,
  input  logic                 perr_in,
  input  logic                 rd,
  output logic [WORD_BITS-1:0] word,
  output logic                 word_valid,
  output logic                 parity_err,
  output logic                 overrun
);

  logic [WORD_BITS-1:0] word_reg;
  logic                 valid_reg;
  logic                 perr_reg;
  logic                 overrun_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_reg    <= '0;
      valid_reg   <= 1'b0;
      perr_reg    <= 1'b0;
      overrun_reg <= 1'b0;
    end else if (load) begin
      // A read in the same cycle frees the register for the incoming word.
      if (!valid_reg || rd) begin
        word_reg  <= word_in;
        perr_reg  <= perr_in;
        valid_reg <= 1'b1;
      end else begin
        overrun_reg <= 1'b1;
      end
    end else if (rd) begin
      valid_reg <= 1'b0;
    end
  end

  assign word       = word_reg;
  assign word_valid = valid_reg;
  assign parity_err = perr_reg;
  assign overrun    = overrun_reg;

endmodule

// File: rtl/sd_word_assembler.sv
// Collects an MSB-first serial word plus odd parity bit and hands it to sd_word_hold.
// Optional stalled-frame timeout is enabled by defining SD_FRAME_TIMEOUT_EN.
module sd_word_assembler
  import sd_defs::*;
#(
  parameter int WORD_BITS = SD_WORD_BITS_DEFAULT
`ifdef SD_FRAME_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 64
`endif
) (
  input  logic                 SIM_CLK,
  input  logic                 SIM_RST,
  input  logic                 DATA,
  input  logic                 SAMPLE,
  input  logic                 START,
  input  logic                 RD,
  output logic [WORD_BITS-1:0] WORD,
  output logic                 WORD_VALID,
  output logic                 PARITY_ERR,
  output logic                 OVERRUN,
  output logic                 ABORT,
  output logic                 BUSY
);

  localparam int CNT_W = $clog2(WORD_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORD_BITS);

  sd_state_t            state_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic [WORD_BITS-1:0] shift_reg;
  logic                 par_reg;
  logic                 abort_reg;
  logic                 busy_reg;
  logic                 timeout;
  logic                 load;
  logic                 perr_in;

`ifdef SD_FRAME_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [IDLE_W-1:0] idle_cnt_reg;

  // Fires on the TIMEOUT_CYCLES-th consecutive busy cycle without a strobe.
  assign timeout = busy_reg && !START && (idle_cnt_reg == IDLE_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
    if (!SIM_RST) begin
      idle_cnt_reg <= '0;
    end else if (!busy_reg || SAMPLE || START || timeout) begin
      idle_cnt_reg <= '0;
    end else begin
      idle_cnt_reg <= idle_cnt_reg + IDLE_W'(1);
    end
  end
`else
  assign timeout = 1'b0;
`endif

  assign load    = (state_reg == ST_PARITY) && SAMPLE && !START && !timeout;
  assign perr_in = !sd_parity_ok(par_reg, DATA);

  always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
    if (!SIM_RST) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      shift_reg <= '0;
      par_reg   <= 1'b0;
      abort_reg <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      abort_reg <= 1'b0;
      if (START) begin
        // New frame; a coincident SAMPLE is bit 0 of it.
        abort_reg <= (state_reg != ST_IDLE);
        busy_reg  <= 1'b1;
        shift_reg <= WORD_BITS'(DATA & SAMPLE);
        par_reg   <= DATA & SAMPLE;
        cnt_reg   <= SAMPLE ? CNT_W'(1) : '0;
        state_reg <= (SAMPLE && (WORD_BITS == 1)) ? ST_PARITY : ST_SHIFT;
      end else if (timeout) begin
        abort_reg <= 1'b1;
        busy_reg  <= 1'b0;
        state_reg <= ST_IDLE;
      end else if (SAMPLE) begin
        case (state_reg)
          ST_SHIFT: begin
            shift_reg <= (shift_reg << 1) | WORD_BITS'(DATA);
            par_reg   <= par_reg ^ DATA;
            cnt_reg   <= cnt_reg + CNT_W'(1);
            if (cnt_reg + CNT_W'(1) == LAST_CNT) begin
              state_reg <= ST_PARITY;
            end
          end
          ST_PARITY: begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  sd_word_hold #(
    .WORD_BITS(WORD_BITS)
  ) u_hold (
    .clk       (SIM_CLK),
    .rst_n     (SIM_RST),
    .load      (load),
    .word_in   (shift_reg),
    .perr_in   (perr_in),
    .rd        (RD),
    .word      (WORD),
    .word_valid(WORD_VALID),
    .parity_err(PARITY_ERR),
    .overrun   (OVERRUN)
  );

  assign ABORT = abort_reg;
  assign BUSY  = busy_reg;

endmodule

// File: tb/tb_sd_word_assembler.sv
// Self-checking bench for sd_word_assembler: frame table, hand-written corner
// sequences and randomized traffic against a frame-level reference model.
module tb_sd_word_assembler;

  localparam int WB = 26;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          data = 1'b0, sample = 1'b0, start = 1'b0, rd = 1'b0;
  logic [WB-1:0] word;
  logic          word_valid, parity_err, overrun, abort, busy;

  int checks = 0;
  int errors = 0;

  sd_word_assembler dut (
    .SIM_CLK   (clk),
    .SIM_RST   (rst_n),
    .DATA      (data),
    .SAMPLE    (sample),
    .START     (start),
    .RD        (rd),
    .WORD      (word),
    .WORD_VALID(word_valid),
    .PARITY_ERR(parity_err),
    .OVERRUN   (overrun),
    .ABORT     (abort),
    .BUSY      (busy)
  );

  always #5 clk = ~clk;

  // Reference model: bits of the frame in progress, plus the holding register.
  logic          bits[$];
  logic          m_busy, m_abort, m_valid, m_perr, m_ovr;
  logic [WB-1:0] m_word;
  int            m_idle;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    bits.delete();
    m_busy = 0; m_abort = 0; m_valid = 0; m_perr = 0; m_ovr = 0; m_word = '0; m_idle = 0;
  endtask

  task automatic model_step(input logic s, input logic smp, input logic d, input logic r);
    logic          complete;
    logic          to_hit;
    logic [WB-1:0] w;
    int            ones;
    complete = 0;
    m_abort  = 0;
`ifdef SD_FRAME_TIMEOUT_EN
    to_hit = m_busy && !s && (m_idle == TO - 1);
`else
    to_hit = 0;
`endif
    if (s) begin
      m_abort = m_busy;
      m_busy  = 1;
      bits.delete();
      if (smp) bits.push_back(d);
    end else if (to_hit) begin
      m_abort = 1;
      m_busy  = 0;
      bits.delete();
    end else if (m_busy && smp) begin
      bits.push_back(d);
      if (bits.size() == WB + 1) begin
        complete = 1;
        m_busy   = 0;
      end
    end
    m_idle = (!m_busy || s || smp) ? 0 : m_idle + 1;
    if (complete) begin
      w = '0; ones = 0;
      for (int i = 0; i < WB; i++) begin
        w = (w << 1) | WB'(bits[i]);
        ones += int'(bits[i]);
      end
      ones += int'(bits[WB]);
      if (!m_valid || r) begin
        m_word  = w;
        m_perr  = (ones % 2) == 0;
        m_valid = 1;
      end else begin
        m_ovr = 1;
      end
    end else if (r) begin
      m_valid = 0;
    end
  endtask

  task automatic compare_model();
    chk("model_word",   32'(word),       32'(m_word));
    chk("model_valid",  32'(word_valid), 32'(m_valid));
    chk("model_perr",   32'(parity_err), 32'(m_perr));
    chk("model_ovr",    32'(overrun),    32'(m_ovr));
    chk("model_abort",  32'(abort),      32'(m_abort));
    chk("model_busy",   32'(busy),       32'(m_busy));
  endtask

  task automatic step(input logic s, input logic smp, input logic d, input logic r);
    start = s; sample = smp; data = d; rd = r;
    @(posedge clk);
    model_step(s, smp, d, r);
    #1;
    start = 0; sample = 0; data = 0; rd = 0;
    compare_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // START, WB data bits MSB first with occasional gaps, then the parity bit.
  task automatic send_frame(input logic [WB-1:0] w, input logic par, input logic rd_last);
    step(1, 0, 0, 0);
    for (int i = WB - 1; i >= 0; i--) begin
      if ($urandom_range(0, 3) == 0) step(0, 0, 0, 0);
      step(0, 1, w[i], 0);
    end
    step(0, 1, par, rd_last);
  endtask

  typedef struct {
    logic [WB-1:0] w;
    logic          par;
    logic          rd_last;
    logic          rd_after;
    logic [WB-1:0] exp_word;
    logic          exp_valid;
    logic          exp_perr;
    logic          exp_ovr;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [WB-1:0] w1;
    int            seen;

    tbl[0] = '{26'h2AAAAAA, 1'b0, 1'b0, 1'b1, 26'h2AAAAAA, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{26'h2AAAAAA, 1'b1, 1'b0, 1'b1, 26'h2AAAAAA, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{26'h0000001, 1'b0, 1'b0, 1'b0, 26'h0000001, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{26'h3FFFFFF, 1'b1, 1'b0, 1'b0, 26'h0000001, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{26'h1234567, 1'b0, 1'b1, 1'b1, 26'h1234567, 1'b1, 1'b1, 1'b1};
    tbl[5] = '{26'h0000000, 1'b1, 1'b0, 1'b1, 26'h0000000, 1'b1, 1'b0, 1'b1};

    // Reset state, checked before any clock edge.
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    chk("reset_word",  32'(word),       32'h0);
    chk("reset_valid", 32'(word_valid), 32'h0);
    chk("reset_perr",  32'(parity_err), 32'h0);
    chk("reset_ovr",   32'(overrun),    32'h0);
    chk("reset_abort", 32'(abort),      32'h0);
    chk("reset_busy",  32'(busy),       32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Frame table.
    for (int i = 0; i < 6; i++) begin
      send_frame(tbl[i].w, tbl[i].par, tbl[i].rd_last);
      chk($sformatf("tbl%0d_word", i),  32'(word),       32'(tbl[i].exp_word));
      chk($sformatf("tbl%0d_valid", i), 32'(word_valid), 32'(tbl[i].exp_valid));
      chk($sformatf("tbl%0d_perr", i),  32'(parity_err), 32'(tbl[i].exp_perr));
      chk($sformatf("tbl%0d_ovr", i),   32'(overrun),    32'(tbl[i].exp_ovr));
      if (tbl[i].rd_after) begin
        step(0, 0, 0, 1);
        chk($sformatf("tbl%0d_rd_valid", i), 32'(word_valid), 32'h0);
        chk($sformatf("tbl%0d_rd_word", i),  32'(word),       32'(tbl[i].exp_word));
      end
      $display("frame %0d: word=%h valid=%0d perr=%0d ovr=%0d", i, word, word_valid, parity_err, overrun);
    end

    // Completion with a read on the same cycle: replaces, no overrun.
    do_reset();
    send_frame(26'h155AA55, 1'b1, 1'b0);
    send_frame(26'h0F0F0F0, 1'b1, 1'b1);
    chk("rdsame_word",  32'(word),       32'h0F0F0F0);
    chk("rdsame_valid", 32'(word_valid), 32'h1);
    chk("rdsame_ovr",   32'(overrun),    32'h0);
    $display("read-on-completion: word=%h ovr=%0d", word, overrun);

    // Asynchronous reset mid-frame, with an unread word held.
    step(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 1'b1, 0);
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    chk("midrst_word",  32'(word),       32'h0);
    chk("midrst_valid", 32'(word_valid), 32'h0);
    chk("midrst_busy",  32'(busy),       32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    send_frame(26'h2AAAAAA, 1'b0, 1'b0);
    chk("postrst_word", 32'(word), 32'h2AAAAAA);
    chk("postrst_perr", 32'(parity_err), 32'h0);
    $display("reset mid-frame: clean frame word=%h", word);

    // Restart after 12 bits; new frame starts with START+SAMPLE coincident.
    do_reset();
    step(1, 0, 0, 0);
    for (int i = 0; i < 12; i++) step(0, 1, 1'b1, 0);
    step(1, 1, 1'b0, 0);
    chk("restart_abort", 32'(abort), 32'h1);
    chk("restart_busy",  32'(busy),  32'h1);
    step(0, 0, 0, 0);
    chk("restart_abort_end", 32'(abort), 32'h0);
    w1 = 26'h0000001;
    for (int i = WB - 2; i >= 0; i--) step(0, 1, w1[i], 0);
    step(0, 1, 1'b0, 0);
    chk("restart_word",  32'(word),       32'h0000001);
    chk("restart_valid", 32'(word_valid), 32'h1);
    chk("restart_perr",  32'(parity_err), 32'h0);
    $display("restart: word=%h perr=%0d", word, parity_err);

    // Stalled frame after 5 bits.
    step(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 1'b0, 0);
`ifdef SD_FRAME_TIMEOUT_EN
    seen = 0;
    for (int i = 1; i <= 100 && seen == 0; i++) begin
      step(0, 0, 0, 0);
      if (abort) seen = i;
    end
    chk("timeout_cycle", 32'(seen),       32'(TO));
    chk("timeout_busy",  32'(busy),       32'h0);
    chk("timeout_valid", 32'(word_valid), 32'h1);
    $display("stall: abort after %0d cycles", seen);
`else
    seen = 0;
    for (int i = 0; i < 210; i++) begin
      step(0, 0, 0, 0);
      if (busy) seen++;
    end
    chk("stall_busy_cycles", 32'(seen), 32'd210);
    $display("stall: busy for %0d cycles", seen);
`endif

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 6,
           1'($urandom), $urandom_range(0, 19) == 0);
    end
    $display("random: 4000 cycles, last word=%h valid=%0d ovr=%0d", word, word_valid, overrun);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sd_word_assembler.md
Name: sd_word_assembler

Overview:
- Downstream consumer of the switch-selector/data sampler's serial DATA line.
- Collects one framed serial word: WORD_BITS data bits, MSB first, then one parity bit.
- Checks odd parity and double-buffers the completed word into a holding register.
- Presents the word to the processor-side input logic with a valid/read handshake and overrun detection.

Parameters:
- WORD_BITS, 26, number of data bits per frame, excluding parity.
- TIMEOUT_CYCLES, 64, maximum SIM_CLK cycles between SAMPLE strobes inside a frame. Used only when SD_FRAME_TIMEOUT_EN is defined.

Ports:
- SIM_CLK  in  1  single system clock; all state changes on the rising edge.
- SIM_RST  in  1  reset, asynchronous, active-low.
- DATA  in  1  serial data bit from the sampler stage.
- SAMPLE  in  1  one-cycle strobe; DATA is valid and captured on this cycle.
- START  in  1  one-cycle frame-start strobe.
- RD  in  1  one-cycle read acknowledge from the consumer.
- WORD  out  WORD_BITS  holding register, MSB = first bit received.
- WORD_VALID  out  1  holding register contains an unread word.
- PARITY_ERR  out  1  parity result for the word in WORD; meaningful only while WORD_VALID=1.
- OVERRUN  out  1  sticky; set when a completed word is dropped; cleared only by reset.
- ABORT  out  1  one-cycle pulse when a frame in progress is discarded.
- BUSY  out  1  asserted in states SHIFT and PARITY.

Behaviour:
- Reset (SIM_RST=0), asynchronous:
  - state=IDLE, bit counter=0, shift register=0.
  - WORD=0, WORD_VALID=0, PARITY_ERR=0, OVERRUN=0, ABORT=0, BUSY=0.
- FSM states: IDLE, SHIFT, PARITY.
- IDLE:
  - SAMPLE is ignored.
  - START → SHIFT, counter=0.
  - If SAMPLE is coincident with START, that DATA is captured as bit 0 and counter=1.
- SHIFT:
  - On each SAMPLE: shift register = {shift[WORD_BITS-2:0], DATA}; counter increments; running parity ^= DATA.
  - When the counter reaches WORD_BITS after a sample → PARITY.
- PARITY:
  - The next SAMPLE captures the parity bit. Frame is good when (XOR of data bits) ^ parity_bit = 1 (odd).
  - Same edge: holding register loads WORD and PARITY_ERR; WORD_VALID=1; FSM → IDLE.
  - Latency: WORD_VALID rises on the clock edge of the parity-bit SAMPLE and is visible the following cycle.
- START while BUSY:
  - Current frame is discarded and ABORT pulses for 1 cycle.
  - FSM restarts SHIFT with counter=0; a coincident SAMPLE is taken as the new bit 0.
  - The holding register is unaffected.
- Handshake:
  - RD with WORD_VALID=1 clears WORD_VALID next cycle. WORD keeps its value.
  - RD with WORD_VALID=0 has no effect.
- Completion while WORD_VALID=1 and no RD in the same cycle:
  - The new word is dropped, OVERRUN is set, and the holding register is unchanged (oldest word preserved).
- Completion and RD in the same cycle:
  - The new word is loaded, WORD_VALID stays 1, and no overrun is flagged.
- Counter width: clog2(WORD_BITS+1). It never wraps, because PARITY is entered exactly at WORD_BITS.
- All outputs are registered.

Optional Feature:
- Macro: SD_FRAME_TIMEOUT_EN.
- Defined:
  - An idle counter runs while BUSY and is cleared on each SAMPLE or START.
  - When it reaches TIMEOUT_CYCLES, the frame is discarded: ABORT pulses for 1 cycle and FSM → IDLE.
  - A SAMPLE on the timeout cycle is dropped.
  - Timeout never touches WORD or WORD_VALID.
- Undefined:
  - No counter is present; a stalled frame waits indefinitely for SAMPLE or START.

Decomposition:
- Shared package/include sd_defs: FSM state encodings (IDLE=0, SHIFT=1, PARITY=2), default WORD_BITS=26, and the odd-parity convention constant.
- One sub-module, sd_word_hold:
  - Holding register, WORD_VALID/RD handshake and OVERRUN logic.
  - Inputs: load strobe, word, and parity flag from the assembler FSM.
- The FSM and shift register stay in the top module.

Test Plan:
- Reset mid-frame: assert SIM_RST low after 10 bits → all outputs 0 immediately, without waiting for a clock. The next START gives a clean frame.
- Good frame: START, then 26 bits of 0x2AAAAAA MSB first, then parity=0 (13 ones, already odd) → WORD=0x2AAAAAA, WORD_VALID=1, PARITY_ERR=0 one cycle after the parity sample.
- Bad parity: same data with parity=1 → WORD=0x2AAAAAA, PARITY_ERR=1. Then RD → WORD_VALID=0 next cycle, WORD unchanged.
- Overrun and simultaneous read:
  - Leave word A unread and complete word B → WORD=A, OVERRUN=1.
  - After reset, complete word C with RD on the same cycle → WORD=C, WORD_VALID=1, OVERRUN=0.
- Restart: START after 12 bits → ABORT pulse of 1 cycle. The following 27-sample frame of 0x0000001 with parity=0 → WORD=0x0000001, PARITY_ERR=0. START+SAMPLE coincident in IDLE captures bit 0.
- With SD_FRAME_TIMEOUT_EN and TIMEOUT_CYCLES=64: stop SAMPLE after 5 bits → ABORT at cycle 64, BUSY=0, WORD_VALID unchanged. Without the macro, BUSY stays 1 for more than 200 cycles.
